// File: rtl/entropy_key_sequencer.sv
// entropy_key_sequencer
// Turns AC97 microphone samples into 256-bit keys. The block paces samples into
// the randomness extractor and guards collection with a repetition-count health
// test. It then latches the extractor buffer as a key and offers it under a
// valid/ack handshake.
//
// Ports:
//   clock, reset_n   system clock, synchronous active-low reset
//   ac97_ready       sample-available level (may stay high several cycles)
//   ac97_data[7:0]   current AC97 sample
//   key_request      request a fresh key (IDLE, or with key_ack in HOLD)
//   key_ack          consumer has taken the key (HOLD only)
//   ext_ready        one-cycle strobe into the extractor
//   ext_data[7:0]    sample presented to the extractor
//   ext_buffer[255:0] extractor output buffer
//   key[255:0]       latched key
//   key_valid        key is fresh and unacknowledged
//   busy             high while discarding, collecting or settling
//   health_fail      one-cycle pulse when a stuck input is detected
//   sample_count[8:0] samples forwarded in the current attempt
module entropy_key_sequencer #(
  parameter int SAMPLES_PER_KEY = 256,
  parameter int DISCARD         = 16,
  parameter int REPEAT_LIMIT    = 8,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         ac97_ready,
  input  logic [7:0]   ac97_data,
  input  logic         key_request,
  input  logic         key_ack,
  output logic         ext_ready,
  output logic [7:0]   ext_data,
  input  logic [255:0] ext_buffer,
  output logic [255:0] key,
  output logic         key_valid,
  output logic         busy,
  output logic         health_fail,
  output logic [8:0]   sample_count
);

  localparam int DW = $clog2(DISCARD + 2);
  localparam int RW = $clog2(REPEAT_LIMIT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISCARD,
    S_COLLECT,
    S_SETTLE,
    S_HOLD
  } state_t;

  // With no warm-up run, a (re)start goes straight to collection.
  localparam state_t START_STATE = (DISCARD == 0) ? S_COLLECT : S_DISCARD;

  state_t          state;
  logic            ready_q;
  logic [7:0]      last_sample;
  logic [RW-1:0]   rep_cnt;
  logic [DW-1:0]   discard_cnt;
  logic [SW-1:0]   settle_cnt;

  logic            rise;
  logic [RW-1:0]   rep_next;
  logic            rep_hit;
  logic [DW-1:0]   discard_next;
  logic [8:0]      count_next;

  // Run length including the current sample; a zero run means "no history".
  function automatic logic [RW-1:0] next_run(input logic [7:0] sample,
                                             input logic [7:0] prev,
                                             input logic [RW-1:0] run);
    if (sample == prev && run != '0)
      return run + RW'(1);
    return RW'(1);
  endfunction

  assign rise         = ac97_ready & ~ready_q;
  assign rep_next     = next_run(ac97_data, last_sample, rep_cnt);
  assign rep_hit      = (rep_next == RW'(REPEAT_LIMIT));
  assign discard_next = discard_cnt + DW'(1);
  assign count_next   = sample_count + 9'd1;
  assign busy         = (state == S_DISCARD) || (state == S_COLLECT) ||
                        (state == S_SETTLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      ready_q      <= 1'b0;
      last_sample  <= '0;
      rep_cnt      <= '0;
      discard_cnt  <= '0;
      settle_cnt   <= '0;
      ext_ready    <= 1'b0;
      ext_data     <= '0;
      key          <= '0;
      key_valid    <= 1'b0;
      health_fail  <= 1'b0;
      sample_count <= '0;
    end else begin
      // Edge detector runs in every state so a level held across a state
      // change never produces a spurious rise.
      ready_q     <= ac97_ready;
      ext_ready   <= 1'b0;
      health_fail <= 1'b0;

      case (state)
        S_IDLE: begin
          if (key_request) begin
            state        <= START_STATE;
            sample_count <= '0;
            discard_cnt  <= '0;
            rep_cnt      <= '0;
          end
        end

        S_DISCARD: begin
          if (rise) begin
            discard_cnt <= discard_next;
            if (discard_next == DW'(DISCARD)) begin
              state   <= S_COLLECT;
              rep_cnt <= '0;
            end
          end
        end

        S_COLLECT: begin
          if (rise) begin
            last_sample <= ac97_data;
            // A stuck sample is dropped and restarts the attempt, even if it
            // would have completed the key.
            if (rep_hit) begin
              health_fail  <= 1'b1;
              sample_count <= '0;
              discard_cnt  <= '0;
              rep_cnt      <= '0;
              state        <= START_STATE;
            end else begin
              rep_cnt      <= rep_next;
              ext_ready    <= 1'b1;
              ext_data     <= ac97_data;
              sample_count <= count_next;
              if (count_next == 9'(SAMPLES_PER_KEY)) begin
                state      <= S_SETTLE;
                settle_cnt <= '0;
              end
            end
          end
        end

        // Give the extractor time to absorb the last strobe before latching.
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES)) begin
            key       <= ext_buffer;
            key_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        S_HOLD: begin
          if (key_ack) begin
            key_valid <= 1'b0;
            if (key_request) begin
              state        <= START_STATE;
              sample_count <= '0;
              discard_cnt  <= '0;
              rep_cnt      <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
